prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side counterpart of the PRBS generator: consumes a serial bit stream
//  one bit per valid strobe and self-synchronises a local LFSR to it.
//  After lock it predicts every bit, flags mismatches and counts them.
//  It drops lock when the error density is too high.
//  Sits behind the ui_in pins of the top-level tile; results are driven onto uo_out.
// PARAMETERS
//  LOCK_CNT     16  consecutive correct predictions needed to declare lock
//  ERR_W        16  width of the saturating error counter
//  UNLOCK_ERRS   8  errors within one window that force loss of lock
//  UNLOCK_WIN   64  window length, in valid bits, for the unlock check
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous active-low reset
//  ena        in   1      checker enable; low forces HUNT and holds the counters
//  bit_in     in   1      received serial data bit
//  bit_valid  in   1      bit_in is sampled on cycles where this is high
//  poly_sel   in   1      0 = PRBS7 (x^7+x^6+1), 1 = PRBS15 (x^15+x^14+1); see CONFIGURATION
//  clear      in   1      synchronous clear of err_count and lock_lost
//  locked     out  1      high while the FSM is in LOCKED
//  err_pulse  out  1      one-cycle pulse for each mismatched bit while LOCKED
//  err_count  out  ERR_W  saturating count of mismatches seen while LOCKED
//  lock_lost  out  1      sticky: set on each LOCKED->HUNT transition caused by errors
// BEHAVIOUR
//  Reset: state=HUNT, lfsr=0, fill/match/window counters=0.
//         All outputs 0 at reset.
//  N = 7 (PRBS7) or 15 (PRBS15). Predicted bit exp = lfsr[N-1]^lfsr[N-2].
//  Cycles with bit_valid=0 change nothing, except the effects of clear and ena.
//  HUNT:
//   - each valid bit: lfsr <= {lfsr[N-2:0], bit_in}; fill++.
//   - when fill reaches N, go to SYNC with match=0.
//  SYNC:
//   - bit_in==exp: lfsr shifts in bit_in; match++.
//     When match reaches LOCK_CNT, go to LOCKED.
//   - bit_in!=exp: go to HUNT with fill=0. This bit is not shifted in.
//   - lfsr==0 (stuck-at-0 line) is invalid: go to HUNT, fill=0.
//  LOCKED:
//   - lfsr free-runs, shifting in exp rather than bit_in.
//   - mismatch: err_pulse=1 on the next cycle; err_count+1, saturating at all-ones;
//     win_err+1.
//   - window counter counts valid bits 0..UNLOCK_WIN-1.
//     On the last bit of the window, win_err clears after that bit's error has been evaluated.
//   - win_err reaching UNLOCK_ERRS: HUNT on the next cycle; fill=0; lock_lost<=1.
//  Latency:
//   - err_pulse and err_count are registered, visible 1 clk after the sampled bit.
//   - locked rises 1 clk after the LOCK_CNT-th consecutive match.
//  Simultaneous events:
//   - clear with an error increment: clear wins, so err_count=0. err_pulse still fires.
//   - clear with an unlock event: lock_lost=0 and state=HUNT.
//  ena=0 forces HUNT and fill=0. err_count and lock_lost are held.
//  Asserting rst_n low mid-stream returns to the reset state immediately; relock starts from HUNT.
//  A poly_sel change while not in HUNT forces HUNT with fill=0.
// CONFIGURATION
//  PRBS_CHK_POLY_SEL_EN defined:
//   - poly_sel is honoured; lfsr is 15 bits wide.
//   - PRBS7 uses bits [6:0]; the upper bits are held at 0.
//  PRBS_CHK_POLY_SEL_EN undefined:
//   - fixed PRBS7; poly_sel is ignored; lfsr is 7 bits wide.
// TESTING
//  1 Clean PRBS7, poly_sel=0, bit_valid=1 every cycle:
//    locked=1 exactly 7+16 valid bits after the first bit, +1 clk; err_count=0 after 1000 bits.
//  2 Locked; flip 3 bits spaced more than 64 apart:
//    3 err_pulses, err_count=3, locked stays 1, lock_lost=0.
//  3 Locked; inject 8 errors inside one 64-bit window:
//    locked=0 one clk after the 8th, lock_lost=1; a clean stream then relocks after 23 bits.
//  4 bit_in held at 0 for 100 bits:
//    locked stays 0 throughout (all-zero rejection).
//  5 clear asserted on the same cycle as an error's count update:
//    err_count=0 and err_pulse=1; a later error gives err_count=1.
//  6 PRBS_CHK_POLY_SEL_EN defined, poly_sel=1, clean PRBS15:
//    lock after 15+16 bits. Mid-stream rst_n low gives all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS checker.
// Loads a local LFSR from the incoming stream (HUNT), confirms it over
// LOCK_CNT consecutive predictions (SYNC), then free-runs (LOCKED), flagging
// and counting mismatches and dropping lock when too many errors land in one
// UNLOCK_WIN-bit window.
// Build option: define PRBS_CHK_POLY_SEL_EN to honour poly_sel (PRBS7 or
// PRBS15, 15-bit LFSR); otherwise the checker is fixed PRBS7 with a 7-bit LFSR.
module prbs_checker #(
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned UNLOCK_WIN  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             poly_sel,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             lock_lost
);

`ifdef PRBS_CHK_POLY_SEL_EN
    localparam int unsigned LW = 15;
`else
    localparam int unsigned LW = 7;
`endif

    localparam int unsigned FILL_W  = 4;
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = (UNLOCK_WIN > 1) ? $clog2(UNLOCK_WIN) : 1;
    localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(UNLOCK_WIN - 1);
    localparam logic [WERR_W-1:0]  WERR_LIM   = WERR_W'(UNLOCK_ERRS);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    logic [LW-1:0]       r_lfsr;
    logic [FILL_W-1:0]   r_fill;
    logic [MATCH_W-1:0]  r_match;
    logic [WIN_W-1:0]    r_win;
    logic [WERR_W-1:0]   r_win_err;
    logic [ERR_W-1:0]    r_err_count;
    logic                r_err_pulse;
    logic                r_locked;
    logic                r_lock_lost;

    logic                w_exp;
    logic [LW-1:0]       w_lfsr_rx;
    logic [LW-1:0]       w_lfsr_fr;
    logic [FILL_W-1:0]   w_fill_last;
    logic                w_mis;
    logic [WERR_W-1:0]   w_werr_inc;
    logic                w_unlock;
    logic                w_err_sat;
    logic                w_lfsr_zero;
    logic                w_poly_chg;

    // Prediction and next-LFSR candidates for the active polynomial.
    // PRBS7 shifts are zero-extended so the upper bits of a wide LFSR stay 0.
    always_comb begin
        w_exp       = r_lfsr[6] ^ r_lfsr[5];
        w_lfsr_rx   = LW'({r_lfsr[5:0], bit_in});
        w_lfsr_fr   = LW'({r_lfsr[5:0], w_exp});
        w_fill_last = FILL_W'(6);
`ifdef PRBS_CHK_POLY_SEL_EN
        if (poly_sel) begin
            w_exp       = r_lfsr[14] ^ r_lfsr[13];
            w_lfsr_rx   = {r_lfsr[13:0], bit_in};
            w_lfsr_fr   = {r_lfsr[13:0], w_exp};
            w_fill_last = FILL_W'(14);
        end
`endif
    end

    assign w_mis       = bit_in ^ w_exp;
    assign w_werr_inc  = r_win_err + WERR_W'(w_mis);
    assign w_unlock    = (w_werr_inc >= WERR_LIM);
    assign w_err_sat   = &r_err_count;
    assign w_lfsr_zero = ~|r_lfsr;

`ifdef PRBS_CHK_POLY_SEL_EN
    logic r_poly;

    // Remember the polynomial in use so a change outside HUNT can restart acquisition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_poly <= 1'b0;
        end else begin
            r_poly <= poly_sel;
        end
    end

    assign w_poly_chg = (poly_sel != r_poly) && (r_state != HUNT);
`else
    logic w_unused_poly;
    assign w_unused_poly = poly_sel;
    assign w_poly_chg    = 1'b0;
`endif

    // Acquisition / tracking FSM with its counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HUNT;
            r_lfsr      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_win_err   <= '0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_err_pulse <= 1'b0;

            if (!ena || w_poly_chg) begin
                r_state  <= HUNT;
                r_fill   <= '0;
                r_locked <= 1'b0;
            end else if (bit_valid) begin
                case (r_state)
                    HUNT: begin
                        r_lfsr <= w_lfsr_rx;
                        r_fill <= r_fill + FILL_W'(1);
                        if (r_fill >= w_fill_last) begin
                            r_state <= SYNC;
                            r_match <= '0;
                        end
                    end

                    SYNC: begin
                        if (w_lfsr_zero || w_mis) begin
                            r_state <= HUNT;
                            r_fill  <= '0;
                        end else begin
                            r_lfsr  <= w_lfsr_rx;
                            r_match <= r_match + MATCH_W'(1);
                            if (r_match == MATCH_LAST) begin
                                r_state   <= LOCKED;
                                r_locked  <= 1'b1;
                                r_win     <= '0;
                                r_win_err <= '0;
                            end
                        end
                    end

                    LOCKED: begin
                        r_lfsr      <= w_lfsr_fr;
                        r_err_pulse <= w_mis;
                        if (w_mis && !w_err_sat) begin
                            r_err_count <= r_err_count + ERR_W'(1);
                        end
                        // The unlock test sees this bit's error before the
                        // end-of-window clear can discard it.
                        if (w_unlock) begin
                            r_state     <= HUNT;
                            r_fill      <= '0;
                            r_locked    <= 1'b0;
                            r_lock_lost <= 1'b1;
                            r_win_err   <= '0;
                        end else if (r_win == WIN_LAST) begin
                            r_win     <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win     <= r_win + WIN_W'(1);
                            r_win_err <= w_werr_inc;
                        end
                    end

                    default: begin
                        r_state  <= HUNT;
                        r_fill   <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end

            // Clear overrides any same-cycle increment or unlock flag.
            if (clear) begin
                r_err_count <= '0;
                r_lock_lost <= 1'b0;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker.
// A queue-based reference model predicts the outputs after every clock the
// driver issues; a monitor pops and compares one entry per clock.
module tb_prbs_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        poly_sel = 1'b0;
    logic        clear = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        lock_lost;

    always #5 clk = ~clk;

    prbs_checker #(
        .LOCK_CNT(16),
        .ERR_W(16),
        .UNLOCK_ERRS(8),
        .UNLOCK_WIN(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .bit_in(bit_in),
        .bit_valid(bit_valid),
        .poly_sel(poly_sel),
        .clear(clear),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .lock_lost(lock_lost)
    );

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic        ll;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   pulse_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- stream source: x^N + x^(N-1) + 1 ----------------
    bit g_reg[$];

    function void gen_seed(int n);
        g_reg.delete();
        for (int i = 0; i < n; i++) g_reg.push_back(bit'($urandom_range(0, 1)));
        g_reg[0] = 1'b1;
    endfunction

    function bit gen_bit();
        bit b;
        b = g_reg[0] ^ g_reg[1];
        g_reg.push_back(b);
        void'(g_reg.pop_front());
        return b;
    endfunction

    // ---------------- reference model ----------------
    typedef enum { M_HUNT, M_SYNC, M_LOCK } mphase_t;
    mphase_t m_phase;
    bit      m_reg[$];   // last N bits the checker believes, oldest first
    int      m_n;
    int      m_run;
    int      m_pos;
    int      m_werr;
    int      m_cnt;
    bit      m_lost;
    bit      m_pulse;

    function void model_reset();
        m_phase = M_HUNT;
        m_reg.delete();
        m_run = 0; m_pos = 0; m_werr = 0; m_cnt = 0;
        m_lost = 1'b0; m_pulse = 1'b0;
    endfunction

    function bit m_all_zero();
        for (int i = 0; i < m_reg.size(); i++) if (m_reg[i]) return 1'b0;
        return 1'b1;
    endfunction

    function void m_shift(bit b);
        m_reg.push_back(b);
        void'(m_reg.pop_front());
    endfunction

    function void model_step(bit v, bit b, bit c, bit e);
        bit p;
        m_pulse = 1'b0;
        if (!e) begin
            m_phase = M_HUNT;
            m_reg.delete();
        end else if (v) begin
            case (m_phase)
                M_HUNT: begin
                    m_reg.push_back(b);
                    if (m_reg.size() == m_n) begin
                        m_phase = M_SYNC;
                        m_run = 0;
                    end
                end
                M_SYNC: begin
                    p = m_reg[0] ^ m_reg[1];
                    if (m_all_zero() || b != p) begin
                        m_phase = M_HUNT;
                        m_reg.delete();
                    end else begin
                        m_shift(b);
                        m_run++;
                        if (m_run == 16) begin
                            m_phase = M_LOCK;
                            m_pos = 0;
                            m_werr = 0;
                        end
                    end
                end
                default: begin
                    p = m_reg[0] ^ m_reg[1];
                    m_shift(p);
                    if (b != p) begin
                        m_pulse = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                        m_werr++;
                    end
                    if (m_werr >= 8) begin
                        m_phase = M_HUNT;
                        m_reg.delete();
                        m_lost = 1'b1;
                    end else begin
                        m_pos++;
                        if (m_pos == 64) begin
                            m_pos = 0;
                            m_werr = 0;
                        end
                    end
                end
            endcase
        end
        if (c) begin
            m_cnt = 0;
            m_lost = 1'b0;
        end
    endfunction

    // ---------------- driver ----------------
    // One call = one clock. Returns 2 time units after the rising edge.
    task automatic step(input bit v, input bit b, input bit c, input bit e);
        exp_t x;
        @(negedge clk);
        bit_valid = v;
        bit_in    = b;
        clear     = c;
        ena       = e;
        model_step(v, b, c, e);
        x.lk = (m_phase == M_LOCK);
        x.ep = m_pulse;
        x.ec = m_cnt[15:0];
        x.ll = m_lost;
        exp_q.push_back(x);
        @(posedge clk);
        #2;
        bit_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic do_reset(input bit p, input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        bit_valid = 1'b0;
        clear = 1'b0;
        ena = 1'b1;
        #1;
        check({tag, "_locked"},    locked,    0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        poly_sel = p;
        m_n = p ? 15 : 7;
        gen_seed(m_n);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_up(input string tag);
        int need;
        need = m_n + 16;
        for (int i = 1; i <= need; i++) begin
            step(1'b1, gen_bit(), 1'b0, 1'b1);
            if (i == need - 1) check({tag, "_not_yet_locked"}, locked, 0);
            if (i == need)     check({tag, "_locked_on_time"}, locked, 1);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (err_pulse === 1'b1) pulse_seen++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("sb_locked",    locked,    mon_e.lk);
            check("sb_err_pulse", err_pulse, mon_e.ep);
            check("sb_err_count", err_count, mon_e.ec);
            check("sb_lock_lost", lock_lost, mon_e.ll);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        int hi;
        int rate;
        bit v;
        bit b;

        // Clean PRBS7, valid every cycle, lock timing and 1000-bit error-free run
        do_reset(1'b0, "rst0");
        lock_up("t1");
        for (int i = 24; i <= 1000; i++) step(1'b1, gen_bit(), 1'b0, 1'b1);
        check("t1_err_count", err_count, 0);
        check("t1_locked", locked, 1);

        // Clean stream with random valid gaps
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? gen_bit() : bit'($urandom_range(0, 1));
            step(v, b, 1'b0, 1'b1);
        end

        // Three isolated errors, 100 valid bits apart
        p0 = pulse_seen;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
            repeat (99) step(1'b1, gen_bit(), 1'b0, 1'b1);
        end
        check("t2_err_count", err_count, 3);
        check("t2_locked", locked, 1);
        check("t2_lock_lost", lock_lost, 0);
        check("t2_pulses", pulse_seen - p0, 3);

        // Eight errors inside the first window after lock force loss of lock
        do_reset(1'b0, "rst_mid3");
        lock_up("t3a");
        for (int e = 0; e < 8; e++) begin
            step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
            if (e == 7) begin
                check("t3_unlocked", locked, 0);
                check("t3_lock_lost", lock_lost, 1);
            end else begin
                repeat (3) step(1'b1, gen_bit(), 1'b0, 1'b1);
            end
        end
        lock_up("t3_relock");
        check("t3_lost_sticky", lock_lost, 1);
        step(1'b1, gen_bit(), 1'b1, 1'b1);
        check("t3_lost_cleared", lock_lost, 0);

        // Stuck-at-0 line never locks
        do_reset(1'b0, "rst4");
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            if (locked === 1'b1) hi++;
        end
        check("t4_never_locked", hi, 0);

        // Clear on the same edge as an error increment
        do_reset(1'b0, "rst5");
        lock_up("t5");
        step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b1, gen_bit(), 1'b0, 1'b1);
        step(1'b1, gen_bit() ^ 1'b1, 1'b1, 1'b1);
        check("t5_clear_wins", err_count, 0);
        check("t5_pulse_fires", err_pulse, 1);
        repeat (10) step(1'b1, gen_bit(), 1'b0, 1'b1);
        step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
        check("t5_count_after", err_count, 1);

        // ena low drops to HUNT and holds the counter
        repeat (3) step(1'b1, gen_bit(), 1'b0, 1'b0);
        check("ena_unlocked", locked, 0);
        check("ena_count_held", err_count, 1);
        lock_up("ena_relock");

        // Random stress: gaps, error bursts, occasional clear and ena drops
        for (int blk = 0; blk < 10; blk++) begin
            rate = $urandom_range(0, 2);
            for (int i = 0; i < 100; i++) begin
                v = ($urandom_range(0, 4) != 0);
                b = v ? gen_bit() : bit'($urandom_range(0, 1));
                if (v && rate == 1 && $urandom_range(0, 39) == 0) b = ~b;
                if (v && rate == 2 && $urandom_range(0, 5) == 0) b = ~b;
                step(v, b, ($urandom_range(0, 99) == 0), ($urandom_range(0, 199) != 0));
            end
        end

        // Mid-stream reset while locked with errors counted
        do_reset(1'b0, "rst_rand");
        lock_up("t6a");
        step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
        step(1'b1, gen_bit() ^ 1'b1, 1'b0, 1'b1);
        check("t6_pre_reset_count", err_count, 2);
        do_reset(1'b0, "t6_mid_reset");
        lock_up("t6_after_reset");

`ifdef PRBS_CHK_POLY_SEL_EN
        // PRBS15 acquisition, random traffic, then mid-stream reset
        do_reset(1'b1, "rst15");
        lock_up("t6_prbs15");
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? gen_bit() : bit'($urandom_range(0, 1));
            if (v && $urandom_range(0, 49) == 0) b = ~b;
            step(v, b, 1'b0, 1'b1);
        end
        do_reset(1'b1, "t6_prbs15_reset");
        lock_up("t6_prbs15_relock");
`endif

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
